// File: rtl/paws_clken_seq.sv
// paws_clken_seq: lock filter, ordered per-domain reset release and
// runtime-reprogrammable clock-enable divider bank, all on one clock.
//
// Ports:
//   clkin         sole clock (fastest PLL output)
//   rstn          synchronous active-low reset
//   pll_locked    PLL lock, asynchronous to clkin
//   div_we        divisor write strobe
//   div_sel       channel index for a divisor write (>= NCH ignored)
//   div_val       new divisor value
//   ce            per-channel one-cycle enable strobes (period div+1)
//   rst_out       per-channel active-high domain resets
//   ready         all channels released, sequencer in RUN
//   lockloss_cnt  saturating lock-loss count, only with
//                 PAWS_CLKSEQ_LOCKLOSS_CNT_EN defined
//
// Build option: PAWS_CLKSEQ_LOCKLOSS_CNT_EN adds the lockloss_cnt port and
// its counter; behaviour is otherwise identical.

module paws_clken_seq #(
  parameter int unsigned         NCH       = 4,
  parameter int unsigned         DIVW      = 8,
  parameter logic [NCH*DIVW-1:0] DIV_INIT  = {NCH{DIVW'(1)}},
  parameter int unsigned         LOCK_FILT = 1024,
  parameter int unsigned         SEQ_GAP   = 16
) (
  input  logic            clkin,
  input  logic            rstn,
  input  logic            pll_locked,
  input  logic            div_we,
  input  logic [2:0]      div_sel,
  input  logic [DIVW-1:0] div_val,
  output logic [NCH-1:0]  ce,
  output logic [NCH-1:0]  rst_out,
  output logic            ready
`ifdef PAWS_CLKSEQ_LOCKLOSS_CNT_EN
  ,
  output logic [7:0]      lockloss_cnt
`endif
);

  localparam int unsigned FW  = $clog2(LOCK_FILT);
  localparam int unsigned GW  = (SEQ_GAP > 1) ? $clog2(SEQ_GAP) : 1;
  localparam int unsigned CHW = $clog2(NCH + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t          state;
  logic            sync1;
  logic            lock_s;
  logic [FW-1:0]   filt_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [CHW-1:0]  nxt_ch;
  logic [NCH-1:0]  rst_d;

  logic [DIVW-1:0] div_q    [NCH];
  logic [DIVW-1:0] pend_q   [NCH];
  logic [NCH-1:0]  pend_v;
  logic [DIVW-1:0] cnt_q    [NCH];
  logic [DIVW-1:0] div_d    [NCH];
  logic [DIVW-1:0] pend_d   [NCH];
  logic [NCH-1:0]  pend_v_d;
  logic [DIVW-1:0] cnt_d    [NCH];
  logic [NCH-1:0]  ce_d;

  // Two-flop synchroniser for the asynchronous lock input
  always_ff @(posedge clkin) begin
    if (!rstn) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
    end
  end

  // Next value of the per-domain resets; losing lock overrides everything
  always_comb begin
    rst_d = rst_out;
    if (!lock_s) begin
      rst_d = '1;
    end else begin
      case (state)
        WAIT_LOCK: rst_d = '1;
        FILTER: begin
          if (filt_cnt == FW'(LOCK_FILT - 1)) rst_d[0] = 1'b0;
        end
        RELEASE: begin
          if (gap_cnt == GW'(SEQ_GAP - 1)) begin
            for (int i = 0; i < int'(NCH); i++) begin
              if (nxt_ch == CHW'(i)) rst_d[i] = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer FSM: lock filter, spaced reset release, RUN
  always_ff @(posedge clkin) begin
    if (!rstn) begin
      state    <= WAIT_LOCK;
      filt_cnt <= '0;
      gap_cnt  <= '0;
      nxt_ch   <= '0;
      ready    <= 1'b0;
      rst_out  <= '1;
    end else begin
      rst_out <= rst_d;
      if (!lock_s) begin
        state    <= WAIT_LOCK;
        filt_cnt <= '0;
        gap_cnt  <= '0;
        nxt_ch   <= '0;
        ready    <= 1'b0;
      end else begin
        case (state)
          WAIT_LOCK: begin
            state    <= FILTER;
            filt_cnt <= '0;
          end
          FILTER: begin
            if (filt_cnt == FW'(LOCK_FILT - 1)) begin
              // channel 0 is released on this same edge
              state   <= RELEASE;
              gap_cnt <= '0;
              nxt_ch  <= CHW'(1);
            end else begin
              filt_cnt <= filt_cnt + FW'(1);
            end
          end
          RELEASE: begin
            // nxt_ch reaching NCH means the last channel fell last cycle
            if (nxt_ch == CHW'(NCH)) begin
              state <= RUN;
              ready <= 1'b1;
            end else if (gap_cnt == GW'(SEQ_GAP - 1)) begin
              gap_cnt <= '0;
              nxt_ch  <= nxt_ch + CHW'(1);
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          RUN: ready <= 1'b1;
          default: state <= WAIT_LOCK;
        endcase
      end
    end
  end

  // Channel dividers: pending divisor is swapped in only at a wrap or while
  // the channel is in reset, so no period is ever truncated or stretched
  always_comb begin
    for (int i = 0; i < int'(NCH); i++) begin
      div_d[i]    = div_q[i];
      pend_d[i]   = pend_q[i];
      pend_v_d[i] = pend_v[i];
      if (pend_v[i] && (rst_out[i] || ce[i])) begin
        div_d[i]    = pend_q[i];
        pend_v_d[i] = 1'b0;
      end
      if (div_we && (int'(div_sel) == i)) begin
        if (rst_out[i]) begin
          div_d[i]    = div_val;
          pend_v_d[i] = 1'b0;
        end else begin
          pend_d[i]   = div_val;
          pend_v_d[i] = 1'b1;
        end
      end
      if (rst_out[i] || ce[i] || rst_d[i]) cnt_d[i] = '0;
      else                                 cnt_d[i] = cnt_q[i] + DIVW'(1);
      ce_d[i] = !rst_d[i] && (cnt_d[i] == div_d[i]);
    end
  end

  always_ff @(posedge clkin) begin
    if (!rstn) begin
      for (int i = 0; i < int'(NCH); i++) begin
        div_q[i]  <= DIV_INIT[i*DIVW +: DIVW];
        pend_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      pend_v <= '0;
      ce     <= '0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        div_q[i]  <= div_d[i];
        pend_q[i] <= pend_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      pend_v <= pend_v_d;
      ce     <= ce_d;
    end
  end

`ifdef PAWS_CLKSEQ_LOCKLOSS_CNT_EN
  // Outside WAIT_LOCK lock_s was high last cycle, so low now is a 1->0 edge
  always_ff @(posedge clkin) begin
    if (!rstn) begin
      lockloss_cnt <= '0;
    end else if ((state != WAIT_LOCK) && !lock_s && (lockloss_cnt != 8'hFF)) begin
      lockloss_cnt <= lockloss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_paws_clken_seq.sv
// Directed bench for paws_clken_seq: NCH=4, DIVW=8, LOCK_FILT=8, SEQ_GAP=4,
// DIV_INIT = {3,2,1,0}. Cycle k = values after posedge k, sampled at negedge.

module tb_paws_clken_seq;

  logic       clkin = 1'b0;
  logic       rstn;
  logic       pll_locked;
  logic       div_we;
  logic [2:0] div_sel;
  logic [7:0] div_val;
  logic [3:0] ce;
  logic [3:0] rst_out;
  logic       ready;
`ifdef PAWS_CLKSEQ_LOCKLOSS_CNT_EN
  logic [7:0] lockloss_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int fall [4];
  int ce1  [4];
  int ce2  [4];
  int rdy_cyc;
  int ce_in_rst;

  paws_clken_seq #(
    .NCH       (4),
    .DIVW      (8),
    .DIV_INIT  ({8'd3, 8'd2, 8'd1, 8'd0}),
    .LOCK_FILT (8),
    .SEQ_GAP   (4)
  ) dut (
    .clkin      (clkin),
    .rstn       (rstn),
    .pll_locked (pll_locked),
    .div_we     (div_we),
    .div_sel    (div_sel),
    .div_val    (div_val),
    .ce         (ce),
    .rst_out    (rst_out),
    .ready      (ready)
`ifdef PAWS_CLKSEQ_LOCKLOSS_CNT_EN
    ,
    .lockloss_cnt (lockloss_cnt)
`endif
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clkin);
    cyc++;
  endtask

  // Step n cycles, recording first reset fall, first two ce after release
  // and the ready rise cycle.
  task automatic observe(input int n);
    for (int i = 0; i < 4; i++) begin
      fall[i] = -1;
      ce1[i]  = -1;
      ce2[i]  = -1;
    end
    rdy_cyc   = -1;
    ce_in_rst = 0;
    repeat (n) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (fall[i] < 0 && !rst_out[i]) fall[i] = cyc;
        if (ce[i]) begin
          if (rst_out[i])      ce_in_rst++;
          else if (ce1[i] < 0) ce1[i] = cyc;
          else if (ce2[i] < 0) ce2[i] = cyc;
        end
      end
      if (rdy_cyc < 0 && ready) rdy_cyc = cyc;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, w, d, a, r;
    int nc1, nce0, nc2, nc3;
    int c1 [3];
    int c2 [2];
    int c3 [2];

    rstn       = 1'b0;
    pll_locked = 1'b0;
    div_we     = 1'b0;
    div_sel    = 3'd0;
    div_val    = 8'd0;
    repeat (3) @(negedge clkin);
    check("reset_rst_out", int'(rst_out), 15);
    check("reset_ce", int'(ce), 0);
    check("reset_ready", int'(ready), 0);
    rstn = 1'b1;
    cyc  = 0;

    // Power-up: lock at cycle 10
    repeat (10) step();
    pll_locked = 1'b1;
    observe(32);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("p1_fall%0d", i), fall[i], 21 + 4 * i);
      check($sformatf("p1_first_ce%0d", i), ce1[i], 21 + 5 * i);
      check($sformatf("p1_period%0d", i), ce2[i] - ce1[i], i + 1);
    end
    check("p1_ready", rdy_cyc, 34);
    check("p1_ce_in_reset", ce_in_rst, 0);

    // Out-of-range select must be ignored
    div_we  = 1'b1;
    div_sel = 3'd6;
    div_val = 8'd0;
    step();
    div_we = 1'b0;

    // Reprogram ch1 to 5 one cycle after a wrap
    t = -1;
    for (int k = 0; k < 10 && t < 0; k++) begin
      step();
      if (ce[1]) t = cyc;
    end
    check("p2_ce1_seen", int'(t >= 0), 1);
    step();
    w       = cyc;
    div_we  = 1'b1;
    div_sel = 3'd1;
    div_val = 8'd5;
    step();
    div_we = 1'b0;
    nc1 = 0; nce0 = 0; nc2 = 0; nc3 = 0;
    c1 = '{-1, -1, -1};
    c2 = '{-1, -1};
    c3 = '{-1, -1};
    for (int k = 0; k < 20; k++) begin
      if (k > 0) step();
      if (ce[0]) nce0++;
      if (ce[1] && nc1 < 3) begin c1[nc1] = cyc; nc1++; end
      if (ce[2] && nc2 < 2) begin c2[nc2] = cyc; nc2++; end
      if (ce[3] && nc3 < 2) begin c3[nc3] = cyc; nc3++; end
    end
    check("p2_ch1_finish_old", c1[0] - w, 1);
    check("p2_ch1_new_first", c1[1] - w, 7);
    check("p2_ch1_new_period", c1[2] - c1[1], 6);
    check("p2_ch0_count", nce0, 20);
    check("p2_ch2_period", c2[1] - c2[0], 3);
    check("p2_ch3_period", c3[1] - c3[0], 4);

    // One-cycle lock drop in RUN
    d = cyc;
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    step();
    check("p3_rst_not_early", int'(rst_out), 0);
    step();
    check("p3_rst_all", int'(rst_out), 15);
    check("p3_ready_low", int'(ready), 0);
    check("p3_ce_low", int'(ce), 0);
    observe(30);
    check("p3_fall0", fall[0] - d, 12);
    check("p3_fall1", fall[1] - d, 16);
    check("p3_fall3", fall[3] - d, 24);
    check("p3_ready", rdy_cyc - d, 25);
    check("p3_ch1_first_ce", ce1[1] - d, 21);
    check("p3_ch1_period_kept", ce2[1] - ce1[1], 6);
    check("p3_ce_in_reset", ce_in_rst, 0);
`ifdef PAWS_CLKSEQ_LOCKLOSS_CNT_EN
    check("p3_lockloss", int'(lockloss_cnt), 1);
`endif

    // Lock glitch at filter count 5 restarts the filter
    pll_locked = 1'b0;
    repeat (4) step();
    a = cyc;
    pll_locked = 1'b1;
    repeat (8) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    observe(16);
    check("p4_fall0", fall[0] - a, 20);
    check("p4_fall1", fall[1] - a, 24);
    check("p4_fall2_pending", fall[2], -1);
    step();
    check("p4_mid_release", int'(rst_out), 12);
`ifdef PAWS_CLKSEQ_LOCKLOSS_CNT_EN
    check("p4_lockloss", int'(lockloss_cnt), 3);
`endif

    // Reset mid-RELEASE after ch1 freed
    rstn = 1'b0;
    step();
    check("p5_rst_all", int'(rst_out), 15);
    check("p5_ready_low", int'(ready), 0);
    check("p5_ce_low", int'(ce), 0);
    rstn = 1'b1;
    r = cyc;
    observe(30);
    check("p5_fall0", fall[0] - r, 11);
    check("p5_fall1", fall[1] - r, 15);
    check("p5_ready", rdy_cyc - r, 24);
    check("p5_ch1_first_ce", ce1[1] - r, 16);
    check("p5_ch1_period_init", ce2[1] - ce1[1], 2);
    check("p5_ch3_first_ce", ce1[3] - r, 26);
`ifdef PAWS_CLKSEQ_LOCKLOSS_CNT_EN
    check("p5_lockloss_cleared", int'(lockloss_cnt), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
